branch_redirect_ctrl: RTL and testbench

Control-flow resolution controller for the EX stage of the RISC-V pipeline. It consumes the combinational `branch_taken` result of the Branch_Unit comparator, together with JAL/JALR decode and the fetch-time prediction, and decides whether the front end must be redirected. On a misprediction it computes the correct next PC and runs a redirect/flush handshake with the fetch stage. It also maintains saturating branch and mispredict statistics counters.

---
 rtl/branch_redirect_ctrl_if.sv | 41 ++++
 rtl/branch_redirect_ctrl.sv | 107 ++++++++++
 tb/tb_branch_redirect_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// Signal bundle between the EX-stage redirect controller and its neighbours
// (EX operands/decode, branch comparator, fetch redirect handshake, statistics).
interface branch_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic             branch_taken;
  logic             ex_pred_taken;
  logic             fetch_ready;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if;
  logic             flush_id;
  logic             ex_stall;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  // Pipeline/fetch side: drives EX state and the fetch handshake.
  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
    output ex_pc, ex_imm, ex_rs1, branch_taken, ex_pred_taken, fetch_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, ex_stall,
    input  branch_cnt, mispredict_cnt
  );

  // Controller side.
  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
    input  ex_pc, ex_imm, ex_rs1, branch_taken, ex_pred_taken, fetch_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, ex_stall,
    output branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow resolution: detects mispredicted branches/jumps, issues a
// held redirect to fetch with flush/stall, and keeps saturating statistics.
module branch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic             cls_jal, cls_jalr, cls_br;
  logic             resolved;
  logic             actual_taken;
  logic             need_redirect;
  logic [XLEN-1:0]  pc_plus_imm;
  logic [XLEN-1:0]  rs1_plus_imm;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fallthrough;
  logic [XLEN-1:0]  correct_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Resolution datapath: class decode with JAL > JALR > branch priority.
  always_comb begin
    cls_jal      = bus.ex_is_jal;
    cls_jalr     = !bus.ex_is_jal && bus.ex_is_jalr;
    cls_br       = !bus.ex_is_jal && !bus.ex_is_jalr && bus.ex_is_branch;
    resolved     = (state_q == S_IDLE) && bus.ex_valid && (cls_jal || cls_jalr || cls_br);

    pc_plus_imm  = bus.ex_pc + bus.ex_imm;
    rs1_plus_imm = bus.ex_rs1 + bus.ex_imm;
    fallthrough  = bus.ex_pc + XLEN'(4);
    target       = cls_jalr ? {rs1_plus_imm[XLEN-1:1], 1'b0} : pc_plus_imm;

    actual_taken = cls_jal || cls_jalr || (cls_br && bus.branch_taken);
    // JALR targets are never predicted, so it always redirects.
    need_redirect = cls_jalr || (actual_taken != bus.ex_pred_taken);
    correct_pc    = actual_taken ? target : fallthrough;
  end

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (resolved) begin
          branch_cnt_d = sat_inc(branch_cnt_q);
          if (need_redirect) begin
            redirect_pc_d    = correct_pc;
            mispredict_cnt_d = sat_inc(mispredict_cnt_q);
            state_d          = S_REDIRECT;
          end
        end
      end
      S_REDIRECT: begin
        if (bus.fetch_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Handshake outputs are pure state decodes, so they drop as soon as rst asserts.
  always_comb begin
    bus.redirect_valid = (state_q == S_REDIRECT);
    bus.flush_if       = (state_q == S_REDIRECT);
    bus.flush_id       = (state_q == S_REDIRECT);
    bus.ex_stall       = (state_q == S_REDIRECT);
    bus.redirect_pc    = redirect_pc_q;
    bus.branch_cnt     = branch_cnt_q;
    bus.mispredict_cnt = mispredict_cnt_q;
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: hand-computed redirect targets,
// handshake timing, counters, saturation and asynchronous reset.
module tb_branch_redirect_ctrl;

  logic clk;
  logic rst;
  int   passes;
  int   total;

  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_redirect_ctrl_if #(.XLEN(32), .CNT_W(4))  sbus ();

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic exp);
    chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(exp));
    chk({tag, ".flush_if"},       32'(bus.flush_if),       32'(exp));
    chk({tag, ".flush_id"},       32'(bus.flush_id),       32'(exp));
    chk({tag, ".ex_stall"},       32'(bus.ex_stall),       32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, ".branch_cnt"},     32'(bus.branch_cnt),     b);
    chk({tag, ".mispredict_cnt"}, 32'(bus.mispredict_cnt), m);
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic tk, input logic pred);
    bus.ex_valid      = v;
    bus.ex_is_branch  = br;
    bus.ex_is_jal     = jal;
    bus.ex_is_jalr    = jalr;
    bus.ex_pc         = pc;
    bus.ex_imm        = imm;
    bus.ex_rs1        = rs1;
    bus.branch_taken  = tk;
    bus.ex_pred_taken = pred;
  endtask

  initial begin
    passes = 0;
    total  = 0;
    rst    = 1'b1;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.fetch_ready    = 1'b1;
    sbus.ex_valid      = 1'b0;
    sbus.ex_is_branch  = 1'b0;
    sbus.ex_is_jal     = 1'b0;
    sbus.ex_is_jalr    = 1'b0;
    sbus.ex_pc         = 32'h0;
    sbus.ex_imm        = 32'h0;
    sbus.ex_rs1        = 32'h0;
    sbus.branch_taken  = 1'b0;
    sbus.ex_pred_taken = 1'b0;
    sbus.fetch_ready   = 1'b1;

    // Reset state
    #2;
    chk_hs("reset", 1'b0);
    chk("reset.redirect_pc", bus.redirect_pc, 32'h0);
    chk_cnt("reset", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_hs("idle", 1'b0);

    // BEQ taken, predicted not-taken; fetch ready immediately
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
    tick();
    chk_hs("beq", 1'b1);
    chk("beq.redirect_pc", bus.redirect_pc, 32'h120);
    chk_cnt("beq", 32'd1, 32'd1);
    // same mispredict still presented in the completing cycle: must be ignored
    tick();
    chk_hs("beq_done", 1'b0);
    chk_cnt("beq_done", 32'd1, 32'd1);

    // Correctly predicted taken branch
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h40, 32'h0, 1'b1, 1'b1);
    tick();
    chk_hs("pred_ok", 1'b0);
    chk_cnt("pred_ok", 32'd2, 32'd1);

    // Not a control transfer although comparator says taken
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h40, 32'h0, 1'b1, 1'b0);
    tick();
    chk_hs("nonbr", 1'b0);
    chk_cnt("nonbr", 32'd2, 32'd1);

    // Not-taken, predicted taken: fall through to pc+4
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h80, 32'h0, 1'b0, 1'b1);
    tick();
    chk_hs("nt", 1'b1);
    chk("nt.redirect_pc", bus.redirect_pc, 32'h204);
    chk_cnt("nt", 32'd3, 32'd2);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_hs("nt_done", 1'b0);

    // JALR with fetch stalled 3 cycles -> 4-cycle REDIRECT
    bus.fetch_ready = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h4, 32'h1001, 1'b0, 1'b0);
    tick();
    chk_hs("jalr_w1", 1'b1);
    chk("jalr_w1.redirect_pc", bus.redirect_pc, 32'h1004);
    chk_cnt("jalr_w1", 32'd4, 32'd3);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h700, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    chk_hs("jalr_w2", 1'b1);
    chk("jalr_w2.redirect_pc", bus.redirect_pc, 32'h1004);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h900, 32'h100, 32'h0, 1'b0, 1'b0);
    tick();
    chk_hs("jalr_w3", 1'b1);
    chk("jalr_w3.redirect_pc", bus.redirect_pc, 32'h1004);
    tick();
    chk_hs("jalr_w4", 1'b1);
    chk("jalr_w4.redirect_pc", bus.redirect_pc, 32'h1004);
    chk_cnt("jalr_w4", 32'd4, 32'd3);
    bus.fetch_ready = 1'b1;
    tick();
    chk_hs("jalr_done", 1'b0);
    chk_cnt("jalr_done", 32'd4, 32'd3);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // JAL target wraps modulo 2^32
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b0);
    tick();
    chk_hs("jal_wrap", 1'b1);
    chk("jal_wrap.redirect_pc", bus.redirect_pc, 32'h4);
    chk_cnt("jal_wrap", 32'd5, 32'd4);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_hs("jal_wrap_done", 1'b0);

    // JAL outranks a not-taken branch flag; predicted taken -> no redirect
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h10, 32'h0, 1'b0, 1'b1);
    tick();
    chk_hs("jal_prio", 1'b0);
    chk_cnt("jal_prio", 32'd6, 32'd4);

    // Asynchronous reset during a stalled REDIRECT
    bus.fetch_ready = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h800, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    chk_hs("pre_rst", 1'b1);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_hs("async_rst", 1'b0);
    chk("async_rst.redirect_pc", bus.redirect_pc, 32'h0);
    chk_cnt("async_rst", 32'h0, 32'h0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_hs("post_rst", 1'b0);
    tick();
    chk_hs("post_rst2", 1'b0);
    bus.fetch_ready = 1'b1;

    // 4-bit counters: 17 mispredicts saturate both at 0xF
    for (int i = 0; i < 17; i++) begin
      sbus.ex_valid      = 1'b1;
      sbus.ex_is_branch  = 1'b1;
      sbus.ex_pc         = 32'h1000;
      sbus.ex_imm        = 32'h8;
      sbus.branch_taken  = 1'b1;
      sbus.ex_pred_taken = 1'b0;
      tick();
      sbus.ex_valid = 1'b0;
      tick();
    end
    chk("small_sat.branch_cnt",     32'(sbus.branch_cnt),     32'hF);
    chk("small_sat.mispredict_cnt", 32'(sbus.mispredict_cnt), 32'hF);
    chk("small_sat.redirect_pc",    sbus.redirect_pc,         32'h1008);

    // 16-bit branch counter saturation: 2^16 + 2 correctly predicted branches
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h10, 32'h0, 1'b0, 1'b0);
    repeat (65538) @(posedge clk);
    #1;
    chk_hs("sat", 1'b0);
    chk_cnt("sat", 32'hFFFF, 32'h0);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h10, 32'h0, 1'b1, 1'b0);
    tick();
    chk_hs("sat_mis", 1'b1);
    chk("sat_mis.redirect_pc", bus.redirect_pc, 32'h2010);
    chk_cnt("sat_mis", 32'hFFFF, 32'h1);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_hs("sat_done", 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
